// File: rtl/silife_pkg.sv
// Shared types and constants for the silife matrix sequencer.
// Holds the sequencer state enum and the 8x8 set-mask packing helper.
package silife_pkg;

    typedef enum logic [1:0] {
        PAUSED  = 2'd0,
        RUNNING = 2'd1,
        DONE    = 2'd2
    } seq_state_t;

    localparam int ROWS = 8;
    localparam int COLS = 8;

    // Row-major placement: row r lands on bits [COLS*r +: COLS].
    function automatic logic [ROWS*COLS-1:0] pack_row(input logic [2:0]      row,
                                                      input logic [COLS-1:0] data);
        logic [ROWS*COLS-1:0] mask;
        mask = '0;
        mask[int'(row)*COLS +: COLS] = data;
        return mask;
    endfunction

endpackage

// File: rtl/silife_gen_timer.sv
// Generation period counter: counts 0..period while enabled and flags a tick
// at the top; a held tick keeps the count parked until it can be issued.
module silife_gen_timer #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                hold,
    input  logic                clr,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] timer;

    // >= rather than == so a period shrunk below the count ticks right away.
    assign tick = en && (timer >= period);

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            timer <= '0;
        end else if (en) begin
            if (!tick)
                timer <= timer + 1'b1;
            else if (!hold)
                timer <= '0;
        end
    end

endmodule

// File: rtl/silife_sequencer.sv
// Sequencer for a silife_matrix: generation pacing, run/pause/step control,
// host row-write arbitration, generation counting and limit halt.
module silife_sequencer
    import silife_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int GEN_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 step,
    input  logic                 clear,
    input  logic [PERIOD_W-1:0]  period,
    input  logic [GEN_W-1:0]     gen_limit,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [2:0]           wr_row,
    input  logic [COLS-1:0]      wr_data,
    output logic                 matrix_enable,
    output logic                 matrix_clear,
    output logic [ROWS*COLS-1:0] set_cells,
    output logic [GEN_W-1:0]     gen_count,
    output logic                 running,
    output logic                 done
);

    seq_state_t       state, state_nxt;
    logic             step_pend, pend_nxt;
    logic             accept, tmr_en, tmr_tick, tick_req, fire, limit_hit;
    logic [GEN_W-1:0] gen_inc;

    assign tmr_en  = (state == RUNNING) && run;
    assign gen_inc = gen_count + 1'b1;

    silife_gen_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .en     (tmr_en),
        .hold   (accept),
        .clr    (clear),
        .period (period),
        .tick   (tmr_tick)
    );

    always_comb begin
        accept    = wr_valid && wr_ready && !clear;
        tick_req  = tmr_tick || ((state == PAUSED) && (step || step_pend));
        // A same-cycle write wins; the tick retries next cycle.
        fire      = tick_req && !accept && !clear;
        limit_hit = (gen_limit != '0) && (gen_inc == gen_limit);
        pend_nxt  = !clear && (state == PAUSED) && (step || step_pend) && accept;

        state_nxt = state;
        case (state)
            PAUSED:  if (run) state_nxt = RUNNING;
            RUNNING: if (!run) state_nxt = PAUSED;
                     else if (fire && limit_hit) state_nxt = DONE;
            DONE:    if (!run) state_nxt = PAUSED;
            default: state_nxt = PAUSED;
        endcase
        if (clear)
            state_nxt = PAUSED;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= PAUSED;
            step_pend     <= 1'b0;
            matrix_clear  <= 1'b1;
            wr_ready      <= 1'b0;
            matrix_enable <= 1'b0;
            set_cells     <= '0;
            gen_count     <= '0;
            running       <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_nxt;
            step_pend     <= pend_nxt;
            matrix_clear  <= clear;
            wr_ready      <= !clear;
            matrix_enable <= fire;
            set_cells     <= accept ? pack_row(wr_row, wr_data) : '0;
            gen_count     <= clear ? '0 : (fire ? gen_inc : gen_count);
            running       <= (state_nxt == RUNNING);
            done          <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_silife_sequencer.sv
// Self-checking bench for silife_sequencer: directed scenarios plus random
// stimulus, every cycle compared against a behavioural model.
module tb_silife_sequencer;

    logic        clk = 1'b0;
    logic        reset, run, step, clear, wr_valid;
    logic [15:0] period, gen_limit;
    logic [2:0]  wr_row;
    logic [7:0]  wr_data;
    logic        wr_ready, matrix_enable, matrix_clear, running, done;
    logic [63:0] set_cells;
    logic [15:0] gen_count;

    silife_sequencer #(.PERIOD_W(16), .GEN_W(16)) dut (
        .clk(clk), .reset(reset), .run(run), .step(step), .clear(clear),
        .period(period), .gen_limit(gen_limit), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_row(wr_row), .wr_data(wr_data),
        .matrix_enable(matrix_enable), .matrix_clear(matrix_clear),
        .set_cells(set_cells), .gen_count(gen_count),
        .running(running), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 paused, 1 running, 2 done.
    int          m_mode, m_timer;
    bit          m_pend, m_en, m_clr, m_rdy;
    logic [15:0] m_gen;
    logic [63:0] m_set;

    task automatic model_step();
        bit acc, ract, want, fire;
        int nmode;
        logic [15:0] ng;
        if (!reset || clear) begin
            m_mode = 0; m_timer = 0; m_pend = 0; m_gen = 0;
            m_en = 0; m_set = 0; m_clr = 1; m_rdy = 0;
        end else begin
            acc   = wr_valid && m_rdy;
            ract  = (m_mode == 1) && run;
            want  = (ract && m_timer >= int'(period)) || (m_mode == 0 && (step || m_pend));
            fire  = want && !acc;
            ng    = m_gen + 16'd1;
            nmode = m_mode;
            if (m_mode == 0) begin
                if (run) nmode = 1;
            end else if (m_mode == 1) begin
                if (!run) nmode = 0;
                else if (fire && gen_limit != 0 && ng == gen_limit) nmode = 2;
            end else begin
                if (!run) nmode = 0;
            end
            if (ract) begin
                if (m_timer >= int'(period)) begin
                    if (!acc) m_timer = 0;
                end else begin
                    m_timer++;
                end
            end
            m_pend = (m_mode == 0) && (step || m_pend) && acc;
            m_set  = acc ? (64'(wr_data) << (8 * int'(wr_row))) : 64'd0;
            m_en   = fire;
            if (fire) m_gen = ng;
            m_clr  = 0;
            m_rdy  = 1;
            m_mode = nmode;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("set_cells", set_cells, m_set);
        check("gen_count", 64'(gen_count), 64'(m_gen));
        check("enable", 64'(matrix_enable), 64'(m_en));
        check("ctl", 64'({matrix_clear, wr_ready, running, done}),
              64'({m_clr, m_rdy, m_mode == 1, m_mode == 2}));
    endtask

    task automatic do_clear();
        clear = 1'b1; cyc(); clear = 1'b0; cyc();
    endtask

    initial begin
        int cnt, first, n;
        reset = 0; run = 0; step = 0; clear = 0; wr_valid = 0;
        period = 0; gen_limit = 0; wr_row = 0; wr_data = 0;

        // reset
        cyc(); cyc();
        check("rst_mclr", 64'(matrix_clear), 64'd1);
        check("rst_rdy", 64'(wr_ready), 64'd0);
        check("rst_outs", {set_cells ^ 64'(gen_count), 61'd0, matrix_enable, running, done}, 64'd0);
        reset = 1; cyc();
        check("rel_mclr", 64'(matrix_clear), 64'd0);
        check("rel_rdy", 64'(wr_ready), 64'd1);

        // free run, P=3
        period = 3; run = 1; cyc();
        check("fr_running", 64'(running), 64'd1);
        cnt = 0; first = 0;
        for (int i = 1; i <= 16; i++) begin
            cyc();
            if (matrix_enable) begin
                cnt++;
                if (first == 0) first = i;
            end
        end
        check("fr_pulses", 64'(cnt), 64'd4);
        check("fr_first", 64'(first), 64'd4);
        check("fr_gen", 64'(gen_count), 64'd4);
        run = 0; cyc(); do_clear();

        // write/tick collision, P=0
        period = 0; run = 1; cyc();
        wr_valid = 1; wr_row = 4; wr_data = 8'h70; cyc();
        check("col_row4", 64'(set_cells[39:32]), 64'h70);
        check("col_en", 64'(matrix_enable), 64'd0);
        wr_valid = 0; cyc();
        check("col_def_en", 64'(matrix_enable), 64'd1);
        check("col_set0", set_cells, 64'd0);
        run = 0; cyc(); do_clear();

        // pause/step
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step = 1; cyc(); cnt += int'(matrix_enable);
            step = 0; cyc(); cnt += int'(matrix_enable);
        end
        check("step_pulses", 64'(cnt), 64'd3);
        check("step_gen", 64'(gen_count), 64'd3);
        period = 100; run = 1; cyc();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step = (i % 2 == 0); cyc(); cnt += int'(matrix_enable);
        end
        step = 0;
        check("run_step", 64'(cnt), 64'd0);
        run = 0; cyc(); do_clear();

        // generation limit
        gen_limit = 5; period = 0; run = 1; cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(); cnt += int'(matrix_enable);
        end
        check("lim_pulses", 64'(cnt), 64'd5);
        check("lim_done", 64'(done), 64'd1);
        check("lim_gen", 64'(gen_count), 64'd5);
        run = 0; cyc();
        check("lim_undone", 64'({done, running}), 64'd0);
        do_clear();

        // clear mid-run, P=1
        gen_limit = 0; period = 1; run = 1;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (gen_count == 16'd7) break;
        end
        check("cmr_reach7", 64'(gen_count), 64'd7);
        clear = 1; cyc();
        check("cmr_mclr", 64'(matrix_clear), 64'd1);
        check("cmr_gen0", 64'(gen_count), 64'd0);
        clear = 0; cyc();
        check("cmr_rerun", 64'(running), 64'd1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(); n++;
            if (matrix_enable) break;
        end
        check("cmr_latency", 64'(n), 64'd2);

        // random
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 99) != 0);
            clear     = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 19) == 0) run = ~run;
            step      = ($urandom_range(0, 3) == 0);
            period    = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) gen_limit = 16'($urandom_range(0, 8));
            wr_valid  = ($urandom_range(0, 2) == 0);
            wr_row    = 3'($urandom);
            wr_data   = 8'($urandom);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/silife_sequencer.md
Name: silife_sequencer

Overview:
Controller that sequences a silife_matrix instance.
- Generates the matrix `enable` pulse at a programmable generation period, with run, pause and single-step modes.
- Arbitrates row-pattern writes from a host port against generation ticks and converts them into one-cycle `set_cells` pulses.
- Counts generations and halts at an optional generation limit.
- Sits between the host/peripheral interface and the matrix datapath.

Parameters:
- PERIOD_W, 16, width of the generation-period register.
- GEN_W, 16, width of the generation counter and limit.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset (0 = reset).
- run  input  1  level; 1 = free-run generations, 0 = paused.
- step  input  1  pulse; while paused, request exactly one generation.
- clear  input  1  pulse; wipe matrix and counters.
- period  input  PERIOD_W  generation period P; sampled every cycle.
- gen_limit  input  GEN_W  halt after this many generations; 0 = unlimited.
- wr_valid  input  1  host row-write request.
- wr_ready  output  1  write accepted when wr_valid && wr_ready.
- wr_row  input  3  target row 0..7.
- wr_data  input  8  bits to set in that row (bit i = column i).
- matrix_enable  output  1  one-cycle generation pulse to the matrix `enable`.
- matrix_clear  output  1  drives the matrix reset (active-high).
- set_cells  output  64  row-major 8x8 set mask to the matrix; row r occupies bits [8r+7:8r].
- gen_count  output  GEN_W  generations executed since the last clear.
- running  output  1  state == RUNNING.
- done  output  1  state == DONE.

Behaviour:
- All outputs are registered.
- Reset values while reset == 0:
  - matrix_clear = 1; all other outputs = 0.
  - wr_ready = 0; state PAUSED; timer = 0.
- First cycle after reset release: matrix_clear = 0 and wr_ready = 1.
- FSM states: PAUSED, RUNNING, DONE.
  - PAUSED -> RUNNING when run == 1.
  - RUNNING -> PAUSED when run == 0. The timer is held, not reset, so the cadence resumes.
  - RUNNING -> DONE when a tick brings gen_count to gen_limit and gen_limit != 0.
  - DONE -> PAUSED when run == 0.
  - DONE ignores step and does not issue ticks.
- Timer in RUNNING:
  - Increments 0..P. At timer == P a tick is issued and the timer returns to 0.
  - Pulses are therefore exactly P+1 cycles apart; P = 0 gives one pulse per cycle.
  - The first pulse appears P+1 cycles after entering RUNNING from a cleared timer.
  - If P changes below the current timer value, the next cycle ticks and the timer wraps to 0.
- Tick: matrix_enable = 1 for one cycle in the cycle after the tick decision. gen_count increments in the same cycle, wrapping at 2^GEN_W-1 -> 0.
- Step:
  - In PAUSED, a step pulse produces exactly one tick, so matrix_enable is high on the following cycle.
  - Step held high produces one tick per cycle.
  - Step in RUNNING or DONE is ignored.
- Writes:
  - wr_ready = 1 except while matrix_clear is high.
  - An accepted write drives set_cells = wr_data << (8*wr_row) for exactly one cycle, in the cycle after acceptance. set_cells is 0 otherwise.
  - One write per cycle, back-to-back allowed.
- Arbitration:
  - If a write is accepted in the same cycle as a tick decision, the write wins.
  - The tick is deferred one cycle: timer held at P, or the step request is remembered.
  - Writes and enable are never high in the same cycle.
- Clear has highest priority and overrides write, step and tick in that cycle.
  - Next cycle: matrix_clear = 1 for one cycle, wr_ready = 0, and all of gen_count, timer, set_cells, matrix_enable and pending step/tick are zeroed.
  - State becomes PAUSED and done = 0.
  - If run is still 1, the state re-enters RUNNING the cycle after.
- Reset asserted mid-operation discards any pending tick, write or step.

Decomposition:
- silife_pkg holds:
  - the seq_state_t enum (PAUSED, RUNNING, DONE);
  - ROWS = 8 and COLS = 8 constants;
  - the set_cells packing helper (row index -> bit offset).
- One natural sub-module, silife_gen_timer: the period counter with hold/clear inputs and a tick output.

Test Plan:
- Reset: reset = 0 for 2 cycles -> matrix_clear = 1, all other outputs 0. Cycle after release: matrix_clear = 0, wr_ready = 1.
- Free run: P = 3, run = 1 held 16 cycles -> matrix_enable pulses at cycles 4, 8, 12, 16 after entry; gen_count = 4.
- Write and tick collision: P = 0, run = 1, wr_valid with row 4, data 0x70 held 1 cycle -> set_cells[39:32] = 0x70 for one cycle. The enable pulse is delayed one cycle and is never coincident with the write.
- Pause/step: run = 0, step pulse x3 spaced 2 cycles -> exactly 3 enable pulses; gen_count = 3; step pulses during run = 1 do not add pulses.
- Limit: gen_limit = 5, P = 0, run = 1 -> 5 enable pulses, then done = 1 with no further pulses. run = 0 -> PAUSED, done = 0.
- Clear mid-run: after gen_count = 7, clear pulse -> matrix_clear = 1 for one cycle, gen_count = 0. With run still 1, the first new pulse arrives P+1 cycles after RUNNING is re-entered.
